// File: rtl/cache_pkg.sv
// Shared types for the cache maintenance sequencer: command codes, FSM state
// encodings, the tag entry layout and geometry helpers.
package cache_pkg;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_INIT  = 3'd1;
  localparam logic [2:0] CMD_CLEAR = 3'd2;
  localparam logic [2:0] CMD_WB    = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    INV,
    RD_TAG,
    CHK,
    WB,
    UPD,
    NEXT,
    DONE
  } maint_state_e;

  typedef enum logic [1:0] {
    LW_IDLE,
    LW_RD_DATA,
    LW_WR_BUS
  } line_wb_state_e;

  typedef struct packed {
    maint_state_e   seq;
    line_wb_state_e line;
  } maint_dbg_t;

  // Tag entry layout at the default geometry (64 sets, 8-word lines).
  localparam int DEF_TAG_WIDTH = 21;

  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  function automatic int index_w(input int line_num);
    return $clog2(line_num);
  endfunction

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int way_w(input int way_num);
    return (way_num > 1) ? $clog2(way_num) : 1;
  endfunction

endpackage

// File: rtl/cache_line_wb.sv
// Writes one cache line back over the Avalon master: per word, one data RAM
// read cycle followed by a bus write held until the slave accepts it.
module cache_line_wb
  import cache_pkg::*;
#(
  parameter int INDEX_W   = 6,
  parameter int WAY_W     = 1,
  parameter int WORD_W    = 3,
  parameter int TAG_WIDTH = 21
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic                      start,
  input  logic [INDEX_W-1:0]        set,
  input  logic [WAY_W-1:0]          way,
  input  logic [TAG_WIDTH-1:0]      tag,
  output logic                      done,
  output logic [INDEX_W+WORD_W-1:0] data_addr,
  output logic [WAY_W-1:0]          data_way,
  output logic                      data_rd,
  input  logic [31:0]               data_rdata,
  output logic [31:0]               m0_address,
  output logic                      m0_write,
  output logic [31:0]               m0_writeData,
  output logic [3:0]                m0_byteEnable,
  input  logic                      m0_waitRequest,
  output line_wb_state_e            dbg_state
);

  line_wb_state_e         state_q, state_d;
  logic [INDEX_W-1:0]     set_q;
  logic [WAY_W-1:0]       way_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [WORD_W-1:0]      word_q;
  logic                   first_q;
  logic [31:0]            wdata_q;
  logic                   last_word;
  logic                   accepted;

  assign last_word = &word_q;
  assign accepted  = (state_q == LW_WR_BUS) && !m0_waitRequest;
  assign done      = accepted && last_word;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LW_IDLE:    if (start) state_d = LW_RD_DATA;
      LW_RD_DATA: state_d = LW_WR_BUS;
      LW_WR_BUS:  if (accepted) state_d = last_word ? LW_IDLE : LW_RD_DATA;
      default:    state_d = LW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= LW_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      word_q  <= '0;
      first_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == LW_RD_DATA);
      if (state_q == LW_IDLE && start) begin
        set_q  <= set;
        way_q  <= way;
        tag_q  <= tag;
        word_q <= '0;
      end else if (accepted && !last_word) begin
        word_q <= word_q + 1'b1;
      end
      // RAM output is only guaranteed for one cycle; keep it for a stalled write.
      if (state_q == LW_WR_BUS && first_q) wdata_q <= data_rdata;
    end
  end

  assign data_rd       = (state_q == LW_RD_DATA);
  assign data_addr     = {set_q, word_q};
  assign data_way      = way_q;
  assign m0_write      = (state_q == LW_WR_BUS);
  assign m0_address    = {tag_q, set_q, word_q, 2'b00};
  assign m0_writeData  = (m0_write && first_q) ? data_rdata : wdata_q;
  assign m0_byteEnable = 4'hF;
  assign dbg_state     = state_q;

endmodule

// File: rtl/cache_maint_seq.sv
// Cache maintenance sequencer: walks every set/way of the tag RAM for
// init/clear/wb. Optional CACHE_MAINT_PERF_EN adds the wb_count output.
module cache_maint_seq
  import cache_pkg::*;
#(
  parameter int  LINE_NUM   = 64,
  parameter int  WAY_NUM    = 2,
  parameter int  LINE_WORDS = 8,
  localparam int INDEX_W    = index_w(LINE_NUM),
  localparam int WAY_W      = way_w(WAY_NUM),
  localparam int WORD_W     = $clog2(LINE_WORDS),
  localparam int OFFSET_W   = offset_w(LINE_WORDS),
  localparam int TAG_WIDTH  = 32 - INDEX_W - OFFSET_W
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic [2:0]                cmd,
  output logic                      cmd_ready,
  output logic                      busy,
  output logic [INDEX_W-1:0]        tag_addr,
  output logic [WAY_W-1:0]          tag_way,
  output logic                      tag_rd,
  input  logic [TAG_WIDTH+1:0]      tag_rdata,
  output logic                      tag_wr,
  output logic [TAG_WIDTH+1:0]      tag_wdata,
  output logic [INDEX_W+WORD_W-1:0] data_addr,
  output logic [WAY_W-1:0]          data_way,
  output logic                      data_rd,
  input  logic [31:0]               data_rdata,
  output logic [31:0]               m0_address,
  output logic                      m0_write,
  output logic [31:0]               m0_writeData,
  output logic [3:0]                m0_byteEnable,
  input  logic                      m0_waitRequest,
  output maint_dbg_t                dbg_state
`ifdef CACHE_MAINT_PERF_EN
  ,
  output logic [15:0]               wb_count
`endif
);

  // Handshakes: cmd is held by upstream until the one-cycle cmd_ready pulse and
  // is only sampled in IDLE; an Avalon write transfers on a cycle with
  // m0_write=1 and m0_waitRequest=0, and every m0_* output is held until then.

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  maint_state_e         state_q, state_d;
  logic [2:0]           code_q;
  logic [INDEX_W-1:0]   set_q;
  logic [WAY_W-1:0]     way_q;
  logic [TAG_WIDTH-1:0] tag_q;
  entry_t               rd_entry;
  logic                 accept;
  logic                 last_line;
  logic                 start_wb;
  logic                 wb_done;
  line_wb_state_e       line_state;

  assign rd_entry  = entry_t'(tag_rdata);
  assign accept    = (state_q == IDLE) && (cmd != CMD_NOP);
  assign last_line = (set_q == INDEX_W'(LINE_NUM - 1)) && (way_q == WAY_W'(WAY_NUM - 1));

  always_comb begin
    state_d  = state_q;
    start_wb = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_INIT:          state_d = INV;
            CMD_CLEAR, CMD_WB: state_d = RD_TAG;
            default:           state_d = DONE;
          endcase
        end
      end
      INV:    if (last_line) state_d = DONE;
      RD_TAG: state_d = CHK;
      CHK: begin
        if (rd_entry.valid && rd_entry.dirty) begin
          start_wb = 1'b1;
          state_d  = WB;
        end else if (code_q == CMD_CLEAR && rd_entry.valid) begin
          state_d = UPD;
        end else begin
          state_d = NEXT;
        end
      end
      WB:      if (wb_done) state_d = UPD;
      UPD:     state_d = NEXT;
      NEXT:    state_d = last_line ? DONE : RD_TAG;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      code_q  <= CMD_NOP;
      set_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        code_q <= cmd;
        set_q  <= '0;
        way_q  <= '0;
      end else if ((state_q == INV || state_q == NEXT) && !last_line) begin
        // Way is the inner loop; the set only moves once all ways are done.
        if (way_q == WAY_W'(WAY_NUM - 1)) begin
          way_q <= '0;
          set_q <= set_q + 1'b1;
        end else begin
          way_q <= way_q + 1'b1;
        end
      end
      if (state_q == CHK) tag_q <= rd_entry.tag;
    end
  end

  assign cmd_ready = (state_q == DONE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign tag_addr  = set_q;
  assign tag_way   = way_q;
  assign tag_rd    = (state_q == RD_TAG);
  assign tag_wr    = (state_q == INV) || (state_q == UPD);
  // Write-back keeps the line valid and clean; clear and init invalidate.
  assign tag_wdata = (state_q == UPD && code_q == CMD_WB) ? {1'b1, 1'b0, tag_q} : '0;
  assign dbg_state = {state_q, line_state};

  cache_line_wb #(
    .INDEX_W  (INDEX_W),
    .WAY_W    (WAY_W),
    .WORD_W   (WORD_W),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_line_wb (
    .clk           (clk),
    .rest          (rest),
    .start         (start_wb),
    .set           (set_q),
    .way           (way_q),
    .tag           (rd_entry.tag),
    .done          (wb_done),
    .data_addr     (data_addr),
    .data_way      (data_way),
    .data_rd       (data_rd),
    .data_rdata    (data_rdata),
    .m0_address    (m0_address),
    .m0_write      (m0_write),
    .m0_writeData  (m0_writeData),
    .m0_byteEnable (m0_byteEnable),
    .m0_waitRequest(m0_waitRequest),
    .dbg_state     (line_state)
  );

`ifdef CACHE_MAINT_PERF_EN
  logic [15:0] wb_count_q;

  always_ff @(posedge clk) begin
    if (rest) begin
      wb_count_q <= '0;
    end else if (accept) begin
      wb_count_q <= '0;
    end else if (wb_done && wb_count_q != 16'hFFFF) begin
      wb_count_q <= wb_count_q + 16'd1;
    end
  end

  assign wb_count = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_maint_seq.sv
// Bench for cache_maint_seq: tag/data RAM models, an Avalon slave with random
// or scripted stalls, and a per-command model of expected tag and bus writes.
module tb_cache_maint_seq;
  import cache_pkg::*;

  localparam int LN  = 64;
  localparam int WN  = 2;
  localparam int LW  = 8;
  localparam int IW  = 6;
  localparam int WDW = 3;
  localparam int OW  = 5;
  localparam int TW  = 21;
  localparam int N   = LN * WN;
  localparam int EW  = 72;

  logic              clk = 1'b0;
  logic              rest = 1'b1;
  logic [2:0]        cmd = 3'd0;
  logic              cmd_ready, busy;
  logic [IW-1:0]     tag_addr;
  logic [0:0]        tag_way;
  logic              tag_rd, tag_wr;
  logic [TW+1:0]     tag_rdata = '0;
  logic [TW+1:0]     tag_wdata;
  logic [IW+WDW-1:0] data_addr;
  logic [0:0]        data_way;
  logic              data_rd;
  logic [31:0]       data_rdata = '0;
  logic [31:0]       m0_address, m0_writeData;
  logic              m0_write;
  logic [3:0]        m0_byteEnable;
  logic              m0_waitRequest = 1'b0;
  maint_dbg_t        dbg_state;
`ifdef CACHE_MAINT_PERF_EN
  logic [15:0]       wb_count;
`endif

  cache_maint_seq dut (
    .clk           (clk),
    .rest          (rest),
    .cmd           (cmd),
    .cmd_ready     (cmd_ready),
    .busy          (busy),
    .tag_addr      (tag_addr),
    .tag_way       (tag_way),
    .tag_rd        (tag_rd),
    .tag_rdata     (tag_rdata),
    .tag_wr        (tag_wr),
    .tag_wdata     (tag_wdata),
    .data_addr     (data_addr),
    .data_way      (data_way),
    .data_rd       (data_rd),
    .data_rdata    (data_rdata),
    .m0_address    (m0_address),
    .m0_write      (m0_write),
    .m0_writeData  (m0_writeData),
    .m0_byteEnable (m0_byteEnable),
    .m0_waitRequest(m0_waitRequest),
    .dbg_state     (dbg_state)
`ifdef CACHE_MAINT_PERF_EN
    ,
    .wb_count      (wb_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM models ----------------
  logic [TW+1:0] tag_mem  [WN][LN];
  logic [31:0]   data_mem [WN][LN][LW];

  always @(posedge clk) begin
    if (tag_rd)  tag_rdata  <= tag_mem[tag_way][tag_addr];
    if (data_rd) data_rdata <= data_mem[data_way][data_addr[IW+WDW-1:WDW]][data_addr[WDW-1:0]];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_bus_q[$];
  logic [EW-1:0] exp_tag_q[$];
  int checks = 0;
  int failures = 0;
  int wait_mode = 0;
  int stall_left = 0;
  int stall_seen = 0;
  int waits, overlap_cnt, unstable, extra_cnt, ready_cnt, busy_cnt;
  logic        hold_pend = 1'b0;
  logic [63:0] hold_val = '0;

  task automatic check_eq(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] tag_ev(input int w, input int s, input logic [TW+1:0] wd);
    logic [EW-1:0] r;
    r = '0;
    r[55:48] = w[7:0];
    r[47:40] = s[7:0];
    r[TW+1:0] = wd;
    return r;
  endfunction

  function automatic logic [EW-1:0] bus_ev(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    logic [EW-1:0] r;
    r = '0;
    r[67:64] = be;
    r[63:32] = a;
    r[31:0]  = d;
    return r;
  endfunction

  // Reference: what a command must do to the current memory image.
  task automatic model_cmd(input logic [2:0] code, output int cycles, output int nwb);
    logic [TW+1:0] e;
    logic [31:0]   addr;
    cycles = 0;
    nwb = 0;
    for (int s = 0; s < LN; s++) begin
      for (int w = 0; w < WN; w++) begin
        e = tag_mem[w][s];
        if (code == CMD_INIT) begin
          exp_tag_q.push_back(tag_ev(w, s, '0));
          cycles += 1;
        end else if (code == CMD_CLEAR || code == CMD_WB) begin
          if (e[TW+1] && e[TW]) begin
            nwb++;
            for (int k = 0; k < LW; k++) begin
              addr = (32'(e[TW-1:0]) << (IW + OW)) + 32'(s * LW * 4) + 32'(k * 4);
              exp_bus_q.push_back(bus_ev(4'hF, addr, data_mem[w][s][k]));
            end
            exp_tag_q.push_back(tag_ev(w, s, (code == CMD_WB) ? {1'b1, 1'b0, e[TW-1:0]} : '0));
            cycles += 4 + 2 * LW;
          end else if (code == CMD_CLEAR && e[TW+1]) begin
            exp_tag_q.push_back(tag_ev(w, s, '0));
            cycles += 4;
          end else begin
            cycles += 3;
          end
        end
      end
    end
  endtask

  // One cycle: decide the slave stall, then observe the DUT at the negedge.
  task automatic step();
    logic [EW-1:0] o;
    @(negedge clk);
    case (wait_mode)
      1: m0_waitRequest = m0_write && ($urandom_range(0, 2) == 0);
      2: begin
        if (m0_write && m0_address[4:2] == 3'd3 && stall_left > 0) begin
          m0_waitRequest = 1'b1;
          stall_left--;
        end else begin
          m0_waitRequest = 1'b0;
        end
      end
      default: m0_waitRequest = 1'b0;
    endcase
    if (int'(tag_rd) + int'(tag_wr) + int'(data_rd) + int'(m0_write) > 1) overlap_cnt++;
    if (hold_pend && (!m0_write || {m0_address, m0_writeData} !== hold_val)) unstable++;
    hold_pend = m0_write && m0_waitRequest;
    hold_val  = {m0_address, m0_writeData};
    if (m0_write && m0_waitRequest) begin
      waits++;
      if (m0_address[4:2] == 3'd3) stall_seen++;
    end
    if (m0_write && !m0_waitRequest) begin
      o = bus_ev(m0_byteEnable, m0_address, m0_writeData);
      if (exp_bus_q.size() == 0) extra_cnt++;
      else check_eq("bus_write", o, exp_bus_q.pop_front());
    end
    if (tag_wr) begin
      o = tag_ev(int'(tag_way), int'(tag_addr), tag_wdata);
      if (exp_tag_q.size() == 0) extra_cnt++;
      else check_eq("tag_write", o, exp_tag_q.pop_front());
    end
    if (cmd_ready) ready_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic clear_counts();
    overlap_cnt = 0; unstable = 0; extra_cnt = 0;
    ready_cnt = 0; busy_cnt = 0; waits = 0; hold_pend = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cmd(input logic [2:0] code, input string name);
    int  mcyc, nwb, a, lat;
    bit  done;
    model_cmd(code, mcyc, nwb);
    clear_counts();
    step();
    cmd  = code;
    a    = cyc;
    done = 1'b0;
    lat  = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      step();
      if (cmd_ready) begin
        done = 1'b1;
        lat  = cyc - a;
        cmd  = CMD_NOP;
      end
    end
    cmd = CMD_NOP;
    check_eq({name, "_done"}, 72'(done), 72'd1);
    check_eq({name, "_latency"}, 72'(lat), 72'(1 + mcyc + waits));
    check_eq({name, "_busy_cycles"}, 72'(busy_cnt), 72'(lat - 1));
    step();
    check_eq({name, "_ready_pulses"}, 72'(ready_cnt), 72'd1);
    check_eq({name, "_bus_left"}, 72'(exp_bus_q.size()), 72'd0);
    check_eq({name, "_tag_left"}, 72'(exp_tag_q.size()), 72'd0);
    check_eq({name, "_extra"}, 72'(extra_cnt), 72'd0);
    check_eq({name, "_overlap"}, 72'(overlap_cnt), 72'd0);
    check_eq({name, "_unstable"}, 72'(unstable), 72'd0);
`ifdef CACHE_MAINT_PERF_EN
    check_eq({name, "_wb_count"}, 72'(wb_count), 72'(nwb));
`endif
    exp_bus_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic clear_mem();
    for (int w = 0; w < WN; w++)
      for (int s = 0; s < LN; s++) begin
        tag_mem[w][s] = '0;
        for (int k = 0; k < LW; k++) data_mem[w][s][k] = $urandom();
      end
  endtask

  task automatic rand_mem(input int dirty_pct);
    logic v, d;
    for (int w = 0; w < WN; w++)
      for (int s = 0; s < LN; s++) begin
        v = ($urandom_range(0, 3) != 0);
        d = v && ($urandom_range(0, 99) < dirty_pct);
        tag_mem[w][s] = {v, d, TW'($urandom_range(0, (1 << TW) - 1))};
        for (int k = 0; k < LW; k++) data_mem[w][s][k] = $urandom();
      end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit seen;
    clear_mem();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 72'(cmd_ready), 72'd0);
    check_eq("rst_busy", 72'(busy), 72'd0);
    check_eq("rst_strobes", 72'({tag_rd, tag_wr, data_rd, m0_write}), 72'd0);
    check_eq("rst_addrs", 72'({tag_addr, data_addr, m0_address}), 72'd0);
    check_eq("rst_data", 72'({m0_writeData, tag_wdata}), 72'd0);
    check_eq("rst_state", 72'(dbg_state.seq), 72'(IDLE));
`ifdef CACHE_MAINT_PERF_EN
    check_eq("rst_wb_count", 72'(wb_count), 72'd0);
`endif
    rest = 1'b0;

    rand_mem(30);
    run_cmd(CMD_INIT, "init");

    wait_mode = 1;
    clear_mem();
    tag_mem[1][5] = {1'b1, 1'b1, 21'h1ABCD};
    for (int k = 0; k < LW; k++) data_mem[1][5][k] = 32'h100 + k;
    tag_mem[0][7]  = {1'b1, 1'b0, 21'h0F0F0};
    tag_mem[1][63] = {1'b1, 1'b0, 21'h12345};
    run_cmd(CMD_WB, "wb_one");

    for (int w = 0; w < WN; w++)
      for (int s = 0; s < LN; s++) tag_mem[w][s] = {1'b1, 1'b0, TW'($urandom())};
    tag_mem[0][0][TW] = 1'b1;
    run_cmd(CMD_CLEAR, "clear_all");

    wait_mode  = 2;
    stall_left = 5;
    stall_seen = 0;
    clear_mem();
    tag_mem[0][2] = {1'b1, 1'b1, TW'($urandom())};
    run_cmd(CMD_WB, "stall");
    check_eq("stall_cycles", 72'(stall_seen), 72'd5);
    wait_mode = 1;

    run_cmd(3'd6, "unknown6");
    run_cmd(3'(4 + $urandom_range(0, 3)), "unknown_rand");

    rand_mem(40);
    tag_mem[0][0] = {1'b1, 1'b1, TW'($urandom())};
    clear_counts();
    step();
    cmd  = CMD_WB;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (m0_write) seen = 1'b1;
    end
    check_eq("rst_mid_reached", 72'(seen), 72'd1);
    rest = 1'b1;
    cmd  = CMD_NOP;
    ready_cnt = 0;
    step();
    check_eq("rst_mid_m0_write", 72'(m0_write), 72'd0);
    check_eq("rst_mid_busy", 72'(busy), 72'd0);
    rest = 1'b0;
    repeat (5) step();
    check_eq("rst_mid_no_ready", 72'(ready_cnt), 72'd0);
    exp_bus_q.delete();
    exp_tag_q.delete();
    run_cmd(CMD_INIT, "reinit");

    rand_mem(0);
    tag_mem[0][3]  = {1'b1, 1'b1, TW'($urandom())};
    tag_mem[1][10] = {1'b1, 1'b1, TW'($urandom())};
    tag_mem[1][40] = {1'b1, 1'b1, TW'($urandom())};
    run_cmd(CMD_WB, "wb_three");
    run_cmd(3'd5, "after_three");

    for (int r = 0; r < 4; r++) begin
      rand_mem(20);
      run_cmd(3'($urandom_range(1, 7)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
